// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared instruction encodings and widths for branch resolution
package branch_resolve_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32 major opcodes that reach the branch unit
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int LINK_OFFSET = 4;

  function automatic logic f3_is_reserved(input logic [2:0] f3);
    return (f3 == F3_RSV2) || (f3 == F3_RSV3);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// rtl/branch_resolve_unit_cmp.sv - combinational branch condition evaluation (branch_cmp)
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func3,
  output logic            cond,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    cond    = 1'b0;
    illegal = f3_is_reserved(func3);
    case (func3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - one-stage branch/jump resolver with handshake and statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_func3,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_mispredict,
  output logic             out_illegal,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  localparam logic [XLEN-1:0]  LINK_INC = XLEN'(LINK_OFFSET);
  localparam logic [XLEN-1:0]  LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            accept;
  logic            cmp_cond;
  logic            cmp_illegal;
  logic            is_jump;
  logic            nx_taken;
  logic            nx_illegal;
  logic            nx_mispredict;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] rs1_sum;
  logic [XLEN-1:0] nx_target;
  logic [XLEN-1:0] nx_link;
  logic [XLEN-1:0] nx_redirect;

  logic [CNT_W-1:0] cnt_branch_q;
  logic [CNT_W-1:0] cnt_mispredict_q;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a       (in_rs1),
    .b       (in_rs2),
    .func3   (in_func3),
    .cond    (cmp_cond),
    .illegal (cmp_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Jumps ignore func3 entirely, so a reserved code only matters for conditionals
  always_comb begin
    is_jump       = in_is_jal || in_is_jalr;
    pc_sum        = in_pc + in_imm;
    rs1_sum       = in_rs1 + in_imm;
    nx_link       = in_pc + LINK_INC;
    nx_taken      = is_jump ? 1'b1 : (cmp_cond && !cmp_illegal);
    nx_illegal    = !is_jump && cmp_illegal;
    nx_target     = in_is_jalr ? (rs1_sum & LSB_MASK) : pc_sum;
    nx_redirect   = nx_taken ? nx_target : nx_link;
    nx_mispredict = (nx_taken != in_pred_taken) ||
                    (nx_taken && (nx_target != in_pred_target));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_link        <= '0;
      out_redirect_pc <= '0;
      out_mispredict  <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_taken       <= nx_taken;
      out_target      <= nx_target;
      out_link        <= nx_link;
      out_redirect_pc <= nx_redirect;
      out_mispredict  <= nx_mispredict;
      out_illegal     <= nx_illegal;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

  // Counters saturate so long-running statistics never alias back to small values
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_branch_q     <= '0;
      cnt_mispredict_q <= '0;
    end else if (accept) begin
      if (cnt_branch_q != CNT_MAX)
        cnt_branch_q <= cnt_branch_q + CNT_ONE;
      if (nx_mispredict && (cnt_mispredict_q != CNT_MAX))
        cnt_mispredict_q <= cnt_mispredict_q + CNT_ONE;
    end
  end

  assign cnt_branch     = cnt_branch_q;
  assign cnt_mispredict = cnt_mispredict_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] redirect;
    logic        mis;
    logic        ill;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_is_jal, in_is_jalr, in_pred_taken;
  logic [2:0]  in_func3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, cnt_clear;
  logic [31:0] out_target, out_link, out_redirect_pc;
  logic [CNT_W-1:0] cnt_branch, cnt_mispredict;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic m_valid;
  logic m_fresh;
  res_t m_res;
  int   m_cb, m_cm;
  int   accepted;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func3(in_func3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_redirect_pc(out_redirect_pc),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .cnt_clear(cnt_clear), .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict)
  );

  function automatic res_t ref_resolve();
    res_t r;
    longint unsigned m32 = 64'h1_0000_0000;
    longint s1 = longint'($signed(in_rs1));
    longint s2 = longint'($signed(in_rs2));
    longint unsigned u1 = longint'(in_rs1);
    longint unsigned u2 = longint'(in_rs2);
    r.ill   = 1'b0;
    r.taken = 1'b0;
    if (in_is_jalr) begin
      r.taken  = 1'b1;
      r.target = 32'(((u1 + longint'(in_imm)) % m32) / 2 * 2);
    end else begin
      r.target = 32'((longint'(in_pc) + longint'(in_imm)) % m32);
      if (in_is_jal) r.taken = 1'b1;
      else if (in_func3 == 3'd0) r.taken = (u1 == u2);
      else if (in_func3 == 3'd1) r.taken = (u1 != u2);
      else if (in_func3 == 3'd4) r.taken = (s1 < s2);
      else if (in_func3 == 3'd5) r.taken = (s1 >= s2);
      else if (in_func3 == 3'd6) r.taken = (u1 < u2);
      else if (in_func3 == 3'd7) r.taken = (u1 >= u2);
      else r.ill = 1'b1;
    end
    r.link     = 32'((longint'(in_pc) + 4) % m32);
    r.redirect = r.taken ? r.target : r.link;
    r.mis      = (r.taken != in_pred_taken) || (r.taken && (r.target != in_pred_target));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready, advance the model, then check every output after the edge
  task automatic step();
    logic acc;
    res_t r;
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    acc = in_valid && (!m_valid || out_ready);
    r   = ref_resolve();
    if (rst) begin
      m_valid = 0; m_fresh = 1; m_res = '0; m_cb = 0; m_cm = 0;
    end else begin
      if (cnt_clear) begin
        m_cb = 0; m_cm = 0;
      end else if (acc) begin
        m_cb = (m_cb < CMAX) ? m_cb + 1 : CMAX;
        if (r.mis) m_cm = (m_cm < CMAX) ? m_cm + 1 : CMAX;
      end
      if (acc) begin
        m_valid = 1; m_fresh = 0; m_res = r; accepted++;
      end else if (out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("cnt_branch", cnt_branch, m_cb);
    chk("cnt_mispredict", cnt_mispredict, m_cm);
    if (m_valid || m_fresh) begin
      chk("out_taken", out_taken, m_res.taken);
      chk("out_target", out_target, m_res.target);
      chk("out_link", out_link, m_res.link);
      chk("out_redirect_pc", out_redirect_pc, m_res.redirect);
      chk("out_mispredict", out_mispredict, m_res.mis);
      chk("out_illegal", out_illegal, m_res.ill);
    end
  endtask

  task automatic set_req(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
    in_valid = 1; in_func3 = f3; in_is_jal = jal; in_is_jalr = jalr;
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm;
    in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  initial begin
    logic [31:0] held;
    rst = 1; in_valid = 0; out_ready = 1; cnt_clear = 0;
    set_req(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    m_valid = 0; m_fresh = 1; m_res = '0; m_cb = 0; m_cm = 0; accepted = 0;
    #2;
    step(); step();
    rst = 0;
    #1;
    chk("ready_after_reset", in_ready, 1'b1);
    chk("data_after_reset", out_target, 32'h0);

    // signed vs unsigned less-than on the same operands
    set_req(3'd4, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 32'h0); step();
    chk("blt_taken", out_taken, 1'b1);
    chk("blt_mispredict", out_mispredict, 1'b1);
    set_req(3'd6, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 32'h0); step();
    chk("bltu_taken", out_taken, 1'b0);
    chk("bltu_mispredict", out_mispredict, 1'b0);

    set_req(3'd0, 0, 1, 32'h1003, 32'h0, 32'h100, 32'h2, 1, 32'h1004); step();
    chk("jalr_target", out_target, 32'h1004);
    chk("jalr_link", out_link, 32'h104);
    chk("jalr_mispredict", out_mispredict, 1'b0);

    set_req(3'd0, 0, 0, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, 1, 32'h4); step();
    chk("beq_wrap_target", out_target, 32'h4);
    chk("beq_wrap_link", out_link, 32'h0);

    set_req(3'd2, 0, 0, 32'h7, 32'h7, 32'h300, 32'h10, 0, 32'h0); step();
    chk("illegal_flag", out_illegal, 1'b1);
    chk("illegal_taken", out_taken, 1'b0);
    chk("illegal_redirect", out_redirect_pc, 32'h304);

    // jal and jalr together: jalr wins
    set_req(3'd2, 1, 1, 32'h2000, 32'h0, 32'h400, 32'h11, 1, 32'h0); step();
    chk("jal_jalr_priority", out_target, 32'h2010);

    // stall with in_valid held, then release
    cnt_clear = 1; in_valid = 0; step(); cnt_clear = 0;
    accepted = 0;
    out_ready = 0;
    set_req(3'd1, 0, 0, 32'h1, 32'h2, 32'h500, 32'h20, 1, 32'h520); step();
    held = out_redirect_pc;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd0, 0, 0, $urandom, $urandom, $urandom, $urandom, 0, 0);
      step();
      chk("stall_ready_low", in_ready, 1'b0);
      chk("stall_hold", out_redirect_pc, held);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_req(3'($urandom_range(0, 7)), 0, 0, $urandom, $urandom, $urandom, $urandom, 0, 0);
      step();
    end
    in_valid = 0; step();
    chk("stall_accept_count", cnt_branch, 4'(accepted));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      set_req(3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              a, b, $urandom, $urandom, 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) in_pred_target = ref_resolve().target;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      cnt_clear = $urandom_range(0, 19) == 0;
      step();
    end
    cnt_clear = 0; out_ready = 1;

    // saturation and clear-beats-accept
    in_valid = 0; cnt_clear = 1; step(); cnt_clear = 0;
    for (int i = 0; i < 20; i++) begin
      set_req(3'd0, 1, 0, 0, 0, 32'(i * 16), 32'h80, 0, 0); step();
    end
    chk("sat_branch", cnt_branch, 4'hF);
    chk("sat_mispredict", cnt_mispredict, 4'hF);
    cnt_clear = 1;
    set_req(3'd0, 1, 0, 0, 0, 32'h40, 32'h80, 0, 0); step();
    cnt_clear = 0;
    chk("clear_branch", cnt_branch, 4'h0);
    chk("clear_mispredict", cnt_mispredict, 4'h0);

    // reset drops a pending result
    out_ready = 0;
    set_req(3'd0, 1, 0, 0, 0, 32'h60, 32'h8, 0, 0); step();
    chk("pending_valid", out_valid, 1'b1);
    rst = 1; cnt_clear = 1; step();
    rst = 0; cnt_clear = 0; in_valid = 0;
    chk("rst_drop_valid", out_valid, 1'b0);
    chk("rst_drop_cnt", cnt_branch, 4'h0);
    chk("rst_drop_data", out_target, 32'h0);
    out_ready = 1; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand, PC and target width.
REQ-002 The block SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: request present.
REQ-006 The block SHALL have port in_ready, output, 1: block can accept a request this cycle.
REQ-007 The block SHALL have port in_func3, input, 3: branch condition code.
REQ-008 The block SHALL have ports in_is_jal and in_is_jalr, input, 1 each: unconditional jump kinds.
REQ-009 The block SHALL have ports in_rs1, in_rs2, in_pc, in_imm, input, XLEN each: operands, instruction PC, sign-extended offset.
REQ-010 The block SHALL have ports in_pred_taken (1) and in_pred_target (XLEN), input: front-end prediction.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-012 The block SHALL have outputs out_taken (1), out_target (XLEN), out_link (XLEN, PC+4), out_redirect_pc (XLEN), out_mispredict (1), out_illegal (1).
REQ-013 The block SHALL have input cnt_clear (1) and outputs cnt_branch and cnt_mispredict (CNT_W each).

Function
REQ-014 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-015 A request SHALL be accepted when in_valid && in_ready; its result SHALL be registered and visible with out_valid=1 on the next cycle (latency 1).
REQ-016 out_valid SHALL clear on out_valid && out_ready with no new acceptance in the same cycle; accept and drain in one cycle SHALL give back-to-back results at full throughput.
REQ-017 While out_valid && !out_ready, every out_* value SHALL hold stable.
REQ-018 Condition by func3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
REQ-019 func3 010/011 on a conditional request SHALL give taken=0 and out_illegal=1; otherwise out_illegal=0.
REQ-020 in_is_jal or in_is_jalr SHALL force taken=1 and ignore func3; if both are set, jalr SHALL take priority.
REQ-021 Target for conditional and jal SHALL be pc+imm; for jalr it SHALL be (rs1+imm) with bit 0 cleared.
REQ-022 All additions SHALL wrap modulo 2^XLEN.
REQ-023 out_link SHALL be pc+4 modulo 2^XLEN.
REQ-024 out_redirect_pc SHALL be out_target if taken, else out_link.
REQ-025 out_mispredict SHALL be (taken != pred_taken) || (taken && target != pred_target).
REQ-026 cnt_branch SHALL increment by 1 per accepted request; cnt_mispredict SHALL increment by 1 per accepted request whose mispredict evaluates to 1.
REQ-027 Both counters SHALL saturate at all-ones and never wrap.
REQ-028 cnt_clear SHALL zero both counters next cycle and take priority over a same-cycle increment.

Reset
REQ-029 rst SHALL set out_valid=0 and both counters to 0.
REQ-030 During and after rst, all out_* data SHALL read 0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.
REQ-032 A request held pending in the output register when rst asserts SHALL be discarded and SHALL not be counted.
REQ-033 rst SHALL take priority over acceptance and cnt_clear.

Structure
REQ-034 func3 codes and the XLEN default SHALL live in the shared package/defines file with the other instruction encodings.
REQ-035 The condition evaluation SHALL be one combinational sub-module, branch_cmp (a, b, func3 -> cond, illegal), parameterised by XLEN.
REQ-036 Handshake, target arithmetic and counters SHALL live in branch_resolve_unit.

Verification
REQ-037 BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, mispredict=1; the same operands as BLTU -> taken=0, mispredict=0.
REQ-038 JALR with rs1=0x1003, imm=2, pc=0x100, pred_target=0x1004 -> target=0x1004, link=0x104, mispredict=0.
REQ-039 BEQ with pc=0xFFFFFFFC, imm=8, equal operands -> target=0x4; link=0x0.
REQ-040 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> one result per cycle, cnt_branch rises by exactly the number accepted.
REQ-041 CNT_W=4: 20 mispredicting requests -> both counters read 0xF; cnt_clear with a same-cycle accept -> both read 0.
REQ-042 func3=010 conditional -> out_illegal=1, taken=0, redirect=pc+4; rst asserted with out_valid=1 -> out_valid=0 and counters 0 next cycle.
